alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 32-bit ALU (ADD/SUB/XOR, registered result, zero flag). It accepts operation requests over valid/ready handshakes, drives the ALU operand and control inputs, and waits out the ALU's registered-output latency. It then returns the result and zero flag to the requester that issued the operation. It sits between the two ALU clients (decode/execute and the address-generation path) and the single ALU instance, and owns every ALU input.

## Interface
Parameters:
- CNT_W, 16, width of the issued-operation counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; also wired to the ALU's reset.
- req0_valid / req1_valid  in  1  requester n has an operation pending.
- req0_ready / req1_ready  out  1  combinational grant; handshake is valid & ready in the same cycle.
- req0_op / req1_op  in  3  ALU control: 000 ADD, 001 SUB, 010 XOR, others undefined (ALU yields 0).
- req0_a, req0_b / req1_a, req1_b  in  32  operands.
- rsp0_valid / rsp1_valid  out  1  one-cycle pulse; result for requester n. No backpressure.
- rsp0_result / rsp1_result  out  32  result, held until the next response to that requester.
- rsp0_zero / rsp1_zero  out  1  ALU zero flag captured with the result.
- alu_a, alu_b  out  32  registered ALU operands.
- alu_ctrl  out  3  registered ALU control.
- alu_r  in  32  ALU registered result.
- alu_zero  in  1  ALU zero flag.
- busy  out  1  high whenever state is not IDLE.
- ops_issued  out  CNT_W  count of accepted handshakes; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - Select a requester: if only one is valid, select it. If both are valid, select the one not equal to last_grant.
  - Assert ready only to the selected requester, and only while it is valid. Ready is 0 in every state other than IDLE.
  - On handshake:
    - Latch op/a/b into alu_ctrl/alu_a/alu_b.
    - Record owner and last_grant.
    - Increment ops_issued.
    - Go to EXEC.
- EXEC: the ALU samples the operands at this cycle's edge. Go to DONE unconditionally.
- DONE: alu_r/alu_zero are valid. At the edge, capture them into rspN_result/rspN_zero for the owner, set rspN_valid for one cycle, and go to IDLE.
- alu_a/alu_b/alu_ctrl hold their values after the operation until the next handshake.
- Undefined op codes are issued unchanged. The response carries result 0 and zero 1.
- Arithmetic wraps modulo 2^32 (the ALU behaviour). The arbiter neither modifies nor checks the result.
- Requesters may drop valid without a handshake. No state changes in that case.

## Timing
- Reset values:
  - state IDLE, busy 0, req*_ready 0.
  - alu_a/alu_b 0, alu_ctrl 000.
  - rsp*_valid 0, rsp*_result 0, rsp*_zero 0.
  - last_grant 1, so requester 0 wins the first tie.
  - ops_issued 0.
- Handshake in cycle T:
  - Operands appear on alu_* in T+1 (EXEC).
  - alu_r is valid in T+2 (DONE).
  - rspN_valid is high in T+3.
- Throughput: one operation per 3 cycles. A new handshake is allowed in the same cycle as the rsp pulse (state is IDLE in T+3).
- busy is high in T+1 and T+2.
- Reset asserted in any state aborts the operation. No response is produced, and the whole reset state is restored on that edge. The ALU clears in the same edge.
- Both requesters valid continuously → grants alternate 0,1,0,1 starting with 0 after reset.

## Test plan
- Single ADD from requester 0: a=5, b=7, handshake at cycle T → alu_a=5/alu_ctrl=000 at T+1; rsp0_valid pulse at T+3 with result 12, zero 0; rsp1_valid stays 0.
- SUB equal operands from requester 1: a=b=0x1234 → rsp1_result 0, rsp1_zero 1; a=0, b=1 → result 0xFFFFFFFF, zero 0.
- Both valid continuously, 4 ops each (XOR a=0xFF00FF00, b=0x0F0F0F0F) → grants 0,1,0,1,…, each rsp = 0xF00FF00F, one response per 3 cycles, ops_issued=8.
- Undefined op 3'b111 from requester 0 → rsp0_result 0, rsp0_zero 1, ops_issued increments.
- Reset asserted in EXEC → no rsp pulse, all outputs at reset values next cycle, next tie is granted to requester 0.
- ops_issued at 2^CNT_W−1 plus one handshake → wraps to 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for the shared ALU: it grants one of two
// requesters, drives the ALU inputs, waits out the ALU latency and returns the result to the owner.
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [31:0]       req0_a,
  input  logic [31:0]       req0_b,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [31:0]       req1_a,
  input  logic [31:0]       req1_b,

  output logic              rsp0_valid,
  output logic [31:0]       rsp0_result,
  output logic              rsp0_zero,

  output logic              rsp1_valid,
  output logic [31:0]       rsp1_result,
  output logic              rsp1_zero,

  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [31:0]       alu_r,
  input  logic              alu_zero,

  output logic              busy,
  output logic [CNT_W-1:0]  ops_issued
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   owner;       // requester that issued the operation in flight
  logic   last_grant;  // most recent winner; the other side wins the next tie

  logic   sel;
  logic   handshake;

  // NOTE: every signal written here gets a default on the first line, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    sel = ~last_grant;
    if (req0_valid && !req1_valid) begin
      sel = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      sel = 1'b1;
    end
  end

  // Ready is only ever offered in IDLE and never while reset is held.
  assign req0_ready = !reset && (state == IDLE) && !sel && req0_valid;
  assign req1_ready = !reset && (state == IDLE) &&  sel && req1_valid;
  assign handshake  = req0_ready || req1_ready;

  assign busy = (state != IDLE);

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= 3'b000;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
      ops_issued  <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (handshake) begin
            alu_a      <= sel ? req1_a  : req0_a;
            alu_b      <= sel ? req1_b  : req0_b;
            alu_ctrl   <= sel ? req1_op : req0_op;
            owner      <= sel;
            last_grant <= sel;
            ops_issued <= ops_issued + 1'b1;
            state      <= EXEC;
          end
        end

        // The ALU registers the operands at the end of this cycle.
        EXEC: begin
          state <= DONE;
        end

        DONE: begin
          if (owner) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= alu_r;
            rsp1_zero   <= alu_zero;
          end else begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= alu_r;
            rsp0_zero   <= alu_zero;
          end
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU closes the loop and a scoreboard
// queue holds the expected response for every accepted operation.
module tb_alu_arbiter;

  localparam int CW = 5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_BAD = 3'b111;

  typedef struct {
    int          id;
    logic [31:0] r;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 0, req1_valid = 0;
  logic req0_ready, req1_ready;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [2:0]  alu_ctrl;
  logic        alu_zero;
  logic        busy;
  logic [CW-1:0] ops_issued;

  exp_t          sb[$];
  logic [CW-1:0] exp_ops = '0;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_r(alu_r), .alu_zero(alu_zero),
    .busy(busy), .ops_issued(ops_issued)
  );

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Shared ALU: registered result and zero flag, cleared by the same reset.
  always @(posedge clk) begin
    if (reset) begin
      alu_r    <= '0;
      alu_zero <= 1'b1;
    end else begin
      alu_r    <= alu_fn(alu_ctrl, alu_a, alu_b);
      alu_zero <= (alu_fn(alu_ctrl, alu_a, alu_b) == 32'd0);
    end
  end

  // Response monitor: every pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!reset && (rsp0_valid || rsp1_valid)) begin
      exp_t e;
      int   id;
      logic [31:0] r;
      logic z;
      total++;
      id = rsp1_valid ? 1 : 0;
      r  = rsp1_valid ? rsp1_result : rsp0_result;
      z  = rsp1_valid ? rsp1_zero : rsp0_zero;
      if (rsp0_valid && rsp1_valid) begin
        bad++;
        $display("FAIL rsp_both: both rsp valid at cycle %0d, required one", cyc);
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: rsp%0d result=%h at cycle %0d, required none", id, r, cyc);
      end else begin
        e = sb.pop_front();
        if (id !== e.id || r !== e.r || z !== e.z) begin
          bad++;
          $display("FAIL rsp_data: got id=%0d result=%h zero=%b, required id=%0d result=%h zero=%b",
                   id, r, z, e.id, e.r, e.z);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 0;
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    sb.delete();
    exp_ops = '0;
  endtask

  // Raise one requester's valid until it handshakes; returns at the EXEC negedge.
  task automatic issue(input int id, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ez,
                       input bit push);
    bit got = 0;
    if (id == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    else         begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
        got = 1;
        @(posedge clk);
        if (push) sb.push_back('{id, er, ez});
        exp_ops++;
      end
      @(negedge clk);
    end
    if (id == 0) req0_valid = 0; else req1_valid = 0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL handshake_timeout: req%0d ready=0 for 20 cycles, required 1", id);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  task automatic check_ops(input string name);
    total++;
    if (ops_issued !== exp_ops) begin
      bad++;
      $display("FAIL %s: ops_issued=%0d, required %0d", name, ops_issued, exp_ops);
    end
  endtask

  task automatic check_reset_state(input string name);
    total++;
    if (busy !== 0 || req0_ready !== 0 || req1_ready !== 0 || alu_a !== 0 || alu_b !== 0 ||
        alu_ctrl !== 0 || rsp0_valid !== 0 || rsp1_valid !== 0 || rsp0_result !== 0 ||
        rsp1_result !== 0 || rsp0_zero !== 0 || rsp1_zero !== 0 || ops_issued !== 0) begin
      bad++;
      $display("FAIL %s: busy=%b rdy=%b%b alu_a=%h alu_b=%h ctrl=%b rspv=%b%b res0=%h res1=%h z=%b%b ops=%0d, required all zero",
               name, busy, req0_ready, req1_ready, alu_a, alu_b, alu_ctrl, rsp0_valid, rsp1_valid,
               rsp0_result, rsp1_result, rsp0_zero, rsp1_zero, ops_issued);
    end
  endtask

  task automatic check_tie(input string name);
    req0_valid = 1;
    req1_valid = 1;
    #1;
    total++;
    if (req0_ready !== 1 || req1_ready !== 0) begin
      bad++;
      $display("FAIL %s: ready0=%b ready1=%b, required 1 0", name, req0_ready, req1_ready);
    end
    req0_valid = 0;
    req1_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_state("reset_values");
    check_tie("reset_first_tie");
  endtask

  task automatic test_single_add();
    issue(0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    total++;
    if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_ctrl !== OP_ADD || busy !== 1) begin
      bad++;
      $display("FAIL add_exec: alu_a=%0d alu_b=%0d ctrl=%b busy=%b, required 5 7 000 1", alu_a, alu_b, alu_ctrl, busy);
    end
    @(negedge clk);
    total++;
    if (busy !== 1 || rsp0_valid !== 0) begin
      bad++;
      $display("FAIL add_done: busy=%b rsp0_valid=%b, required 1 0", busy, rsp0_valid);
    end
    @(negedge clk);
    total++;
    if (rsp0_valid !== 1 || rsp0_result !== 32'd12 || rsp0_zero !== 0 || rsp1_valid !== 0 || busy !== 0) begin
      bad++;
      $display("FAIL add_rsp: rsp0_valid=%b result=%0d zero=%b rsp1_valid=%b busy=%b, required 1 12 0 0 0",
               rsp0_valid, rsp0_result, rsp0_zero, rsp1_valid, busy);
    end
    @(negedge clk);
    total++;
    if (rsp0_valid !== 0 || rsp0_result !== 32'd12 || alu_a !== 32'd5) begin
      bad++;
      $display("FAIL add_hold: rsp0_valid=%b result=%0d alu_a=%0d, required 0 12 5", rsp0_valid, rsp0_result, alu_a);
    end
    check_ops("add_ops");
  endtask

  task automatic test_sub();
    issue(1, OP_SUB, 32'h1234, 32'h1234, 32'd0, 1'b1, 1);
    drain();
    issue(1, OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1);
    drain();
    @(negedge clk);
    total++;
    if (rsp1_result !== 32'hFFFF_FFFF || rsp1_zero !== 0) begin
      bad++;
      $display("FAIL sub_hold: rsp1_result=%h zero=%b, required ffffffff 0", rsp1_result, rsp1_zero);
    end
  endtask

  task automatic test_back_to_back();
    int n0 = 0, n1 = 0, exp_id = 0, last_hs = -1;
    do_reset();
    req0_op = OP_XOR; req0_a = 32'hFF00_FF00; req0_b = 32'h0F0F_0F0F;
    req1_op = OP_XOR; req1_a = 32'hFF00_FF00; req1_b = 32'h0F0F_0F0F;
    req0_valid = 1;
    req1_valid = 1;
    for (int k = 0; k < 60 && (n0 < 4 || n1 < 4); k++) begin
      #1;
      if (req0_ready || req1_ready) begin
        int id = req1_ready ? 1 : 0;
        total++;
        if (id != exp_id) begin
          bad++;
          $display("FAIL b2b_grant: grant=%0d at cycle %0d, required %0d", id, cyc, exp_id);
        end
        if (last_hs >= 0) begin
          total++;
          if (cyc - last_hs != 3) begin
            bad++;
            $display("FAIL b2b_spacing: %0d cycles between grants, required 3", cyc - last_hs);
          end
        end
        last_hs = cyc;
        sb.push_back('{id, 32'hF00F_F00F, 1'b0});
        exp_ops++;
        if (id == 0) n0++; else n1++;
        exp_id ^= 1;
      end
      @(negedge clk);
      req0_valid = (n0 < 4);
      req1_valid = (n1 < 4);
    end
    req0_valid = 0;
    req1_valid = 0;
    total++;
    if (n0 != 4 || n1 != 4) begin
      bad++;
      $display("FAIL b2b_count: grants %0d/%0d, required 4/4", n0, n1);
    end
    drain();
    check_ops("b2b_ops");
    total++;
    if (ops_issued !== 8) begin
      bad++;
      $display("FAIL b2b_ops8: ops_issued=%0d, required 8", ops_issued);
    end
  endtask

  task automatic test_undefined_op();
    issue(0, OP_BAD, 32'hDEAD_BEEF, 32'h1, 32'd0, 1'b1, 1);
    total++;
    if (alu_ctrl !== OP_BAD) begin
      bad++;
      $display("FAIL undef_ctrl: alu_ctrl=%b, required 111", alu_ctrl);
    end
    drain();
    check_ops("undef_ops");
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    issue(0, OP_ADD, 32'd9, 32'd9, 32'd0, 1'b0, 0);
    reset = 1;
    @(posedge clk);
    #1;
    check_reset_state("abort_values");
    @(negedge clk);
    reset = 0;
    exp_ops = '0;
    for (int k = 0; k < 4; k++) begin
      if (rsp0_valid || rsp1_valid) pulses++;
      @(negedge clk);
    end
    total++;
    if (pulses != 0 || busy !== 0) begin
      bad++;
      $display("FAIL abort_quiet: %0d rsp pulses busy=%b after abort, required 0 0", pulses, busy);
    end
    check_tie("abort_tie");
  endtask

  task automatic test_wrap();
    logic [31:0] a, b;
    do_reset();
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      a = i * 32'h0101_0101;
      b = 32'hFFFF_FFF0 + i;
      issue(i % 2, OP_ADD, a, b, a + b, (a + b) == 0, 1);
    end
    drain();
    check_ops("wrap_max");
    total++;
    if (ops_issued !== {CW{1'b1}}) begin
      bad++;
      $display("FAIL wrap_full: ops_issued=%0d, required %0d", ops_issued, (1 << CW) - 1);
    end
    issue(1, OP_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd0, 1'b1, 1);
    drain();
    total++;
    if (ops_issued !== '0) begin
      bad++;
      $display("FAIL wrap_zero: ops_issued=%0d, required 0", ops_issued);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_sub();
    test_back_to_back();
    test_undefined_op();
    test_reset_abort();
    test_wrap();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule
